// File: rtl/rx_frame_if.sv
// Byte stream bundle between the UART receiver, the frame controller and the
// downstream payload consumer.
interface rx_frame_if;
   logic       i_rx_stb;
   logic [7:0] i_rx_data;
   logic       o_valid;
   logic       i_ready;
   logic [7:0] o_data;
   logic       o_last;
   logic       o_frame_ok;
   logic       o_frame_err;
   logic [1:0] o_err_code;

   modport master (
      output i_rx_stb, i_rx_data, i_ready,
      input  o_valid, o_data, o_last, o_frame_ok, o_frame_err, o_err_code
   );

   modport slave (
      input  i_rx_stb, i_rx_data, i_ready,
      output o_valid, o_data, o_last, o_frame_ok, o_frame_err, o_err_code
   );
endinterface

// File: rtl/rx_frame_ctrl.sv
// Frame receiver: hunts for SYNC_BYTE, then takes a length, payload and a
// zero-sum checksum; payload streams out through a small FIFO with frame status.
module rx_frame_ctrl #(
   parameter logic [7:0]              SYNC_BYTE      = 8'h7E,
   parameter logic [7:0]              MAX_LEN        = 8'd64,
   parameter int                      TIMEOUT_BITS   = 16,
   parameter logic [TIMEOUT_BITS-1:0] TIMEOUT_CYCLES = 16'd8680,
   parameter int                      FIFO_LG        = 2
) (
   input logic       i_clk,
   input logic       i_reset_n,
   rx_frame_if.slave bus
);

   localparam logic [1:0] S_HUNT    = 2'd0;
   localparam logic [1:0] S_LEN     = 2'd1;
   localparam logic [1:0] S_PAYLOAD = 2'd2;
   localparam logic [1:0] S_CSUM    = 2'd3;

   localparam logic [1:0] ERR_CSUM = 2'b00;
   localparam logic [1:0] ERR_LEN  = 2'b01;
   localparam logic [1:0] ERR_TMO  = 2'b10;
   localparam logic [1:0] ERR_OVF  = 2'b11;

   localparam int                      DEPTH      = 1 << FIFO_LG;
   localparam logic [TIMEOUT_BITS-1:0] TMO_RELOAD = TIMEOUT_CYCLES - 1'b1;

   logic                    run_q;
   logic [1:0]              state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [7:0]              sum_q, sum_d;
   logic [7:0]              sum_chk;
   logic                    ovf_q, ovf_d;
   logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
   logic                    ok_q, ok_d;
   logic                    err_q, err_d;
   logic [1:0]              code_q, code_d;

   logic [8:0]              mem_q [DEPTH];
   logic [FIFO_LG-1:0]      wr_q, rd_q;
   logic [FIFO_LG:0]        lvl_q, lvl_d;
   logic                    fifo_empty, fifo_full, fifo_room;
   logic                    push_req, push_last, push_ok, pop;

   // Deassertion is retimed by one flop so the logic first acts on the second edge.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) run_q <= 1'b0;
      else            run_q <= 1'b1;
   end

   assign fifo_empty = (lvl_q == '0);
   assign fifo_full  = lvl_q[FIFO_LG];
   assign pop        = !fifo_empty && bus.i_ready;
   assign fifo_room  = !fifo_full || pop;
   assign push_ok    = push_req && fifo_room;
   assign sum_chk    = sum_q + bus.i_rx_data;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      ovf_d     = ovf_q;
      tmo_d     = tmo_q;
      ok_d      = 1'b0;
      err_d     = 1'b0;
      code_d    = code_q;
      push_req  = 1'b0;
      push_last = 1'b0;
      if (bus.i_rx_stb) begin
         // A byte always wins over a timeout expiring in the same cycle.
         tmo_d = TMO_RELOAD;
         case (state_q)
            S_HUNT: begin
               if (bus.i_rx_data == SYNC_BYTE) begin
                  state_d = S_LEN;
                  ovf_d   = 1'b0;
               end
            end
            S_LEN: begin
               if (bus.i_rx_data == 8'd0 || bus.i_rx_data > MAX_LEN) begin
                  err_d   = 1'b1;
                  code_d  = ERR_LEN;
                  state_d = S_HUNT;
               end else begin
                  cnt_d   = bus.i_rx_data;
                  sum_d   = bus.i_rx_data;
                  state_d = S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               sum_d     = sum_chk;
               cnt_d     = cnt_q - 8'd1;
               push_req  = 1'b1;
               push_last = (cnt_q == 8'd1);
               if (!fifo_room) ovf_d = 1'b1;
               if (cnt_q == 8'd1) state_d = S_CSUM;
            end
            default: begin
               state_d = S_HUNT;
               if (ovf_q) begin
                  err_d  = 1'b1;
                  code_d = ERR_OVF;
               end else if (sum_chk != 8'd0) begin
                  err_d  = 1'b1;
                  code_d = ERR_CSUM;
               end else begin
                  ok_d = 1'b1;
               end
            end
         endcase
      end else if (state_q != S_HUNT) begin
         if (tmo_q == '0) begin
            err_d   = 1'b1;
            code_d  = ERR_TMO;
            state_d = S_HUNT;
         end else begin
            tmo_d = tmo_q - 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= S_HUNT;
         cnt_q   <= '0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
         tmo_q   <= '0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= '0;
      end else if (run_q) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         ovf_q   <= ovf_d;
         tmo_q   <= tmo_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   always_comb begin
      lvl_d = lvl_q;
      if (push_ok && !pop)      lvl_d = lvl_q + 1'b1;
      else if (!push_ok && pop) lvl_d = lvl_q - 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else if (run_q) begin
         if (push_ok) wr_q <= wr_q + 1'b1;
         if (pop)     rd_q <= rd_q + 1'b1;
         lvl_q <= lvl_d;
      end
   end

   // Storage is never reset; the outputs are masked while the FIFO is empty.
   always_ff @(posedge i_clk) begin
      if (run_q && push_ok) mem_q[wr_q] <= {push_last, bus.i_rx_data};
   end

   assign bus.o_valid     = !fifo_empty;
   assign bus.o_data      = fifo_empty ? 8'h00 : mem_q[rd_q][7:0];
   assign bus.o_last      = fifo_empty ? 1'b0  : mem_q[rd_q][8];
   assign bus.o_frame_ok  = ok_q;
   assign bus.o_frame_err = err_q;
   assign bus.o_err_code  = code_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: directed vector table, hand-written corner sequences
// and a randomized frame stream checked against a queue-based reference model.
module tb_rx_frame_ctrl;

   localparam logic [7:0] SYNC  = 8'h7E;
   localparam logic [7:0] MAXL  = 8'd64;
   localparam int         TMO   = 8680;
   localparam int         DEPTH = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   rx_frame_if bus();

   rx_frame_ctrl #(
      .SYNC_BYTE(8'h7E),
      .MAX_LEN(8'd64),
      .TIMEOUT_BITS(16),
      .TIMEOUT_CYCLES(16'd8680),
      .FIFO_LG(2)
   ) dut (
      .i_clk(clk),
      .i_reset_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       stb;
      logic [7:0] d;
      logic       rdy;
      logic       v;
      logic [7:0] od;
      logic       ol;
      logic       ok;
      logic       err;
      logic [1:0] code;
   } vec_t;

   vec_t tbl[$];

   // reference model state: frame position rather than a state machine
   logic [8:0] mq[$];
   bit         m_in_frame;
   int         m_pos, m_len, m_idle;
   logic [7:0] m_sum;
   bit         m_ovf, m_ok, m_err;
   logic [1:0] m_code;
   int         rdy_pct;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic stb, input logic [7:0] d, input logic rdy);
      bus.i_rx_stb  = stb;
      bus.i_rx_data = d;
      bus.i_ready   = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic stb, input logic [7:0] d, input logic v, input logic [7:0] od,
                      input logic ol, input logic ok, input logic err, input logic [1:0] code);
      vec_t e;
      e.stb = stb; e.d = d; e.rdy = 1'b1; e.v = v; e.od = od; e.ol = ol;
      e.ok = ok; e.err = err; e.code = code;
      tbl.push_back(e);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " valid"}, 32'(bus.o_valid), 32'd0);
      check({tag, " data"},  32'(bus.o_data), 32'd0);
      check({tag, " last"},  32'(bus.o_last), 32'd0);
      check({tag, " ok"},    32'(bus.o_frame_ok), 32'd0);
      check({tag, " err"},   32'(bus.o_frame_err), 32'd0);
      check({tag, " code"},  32'(bus.o_err_code), 32'd0);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async reset");
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      rst_n = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      mq.delete();
      m_in_frame = 0;
      m_idle     = 0;
   endtask

   // One clock of the reference: frame rules applied to a byte, FIFO as a queue.
   task automatic model(input logic stb, input logic [7:0] d, input logic rdy);
      bit         popped, room;
      logic [7:0] s;
      popped = (mq.size() != 0) && rdy;
      room   = (mq.size() < DEPTH) || popped;
      if (popped) void'(mq.pop_front());
      m_ok  = 0;
      m_err = 0;
      if (stb) begin
         m_idle = 0;
         if (!m_in_frame) begin
            if (d == SYNC) begin
               m_in_frame = 1; m_pos = 0; m_ovf = 0;
            end
         end else if (m_pos == 0) begin
            if (d == 8'd0 || d > MAXL) begin
               m_err = 1; m_code = 2'b01; m_in_frame = 0;
            end else begin
               m_len = int'(d); m_sum = d; m_pos = 1;
            end
         end else if (m_pos <= m_len) begin
            m_sum = m_sum + d;
            if (room) mq.push_back({(m_pos == m_len), d});
            else      m_ovf = 1;
            m_pos++;
         end else begin
            m_in_frame = 0;
            s = m_sum + d;
            if (m_ovf)          begin m_err = 1; m_code = 2'b11; end
            else if (s != 8'd0) begin m_err = 1; m_code = 2'b00; end
            else                m_ok = 1;
         end
      end else if (m_in_frame) begin
         m_idle++;
         if (m_idle == TMO) begin
            m_err = 1; m_code = 2'b10; m_in_frame = 0;
         end
      end
   endtask

   task automatic rstep(input logic stb, input logic [7:0] d);
      logic rdy;
      rdy = ($urandom_range(0, 99) < rdy_pct);
      model(stb, d, rdy);
      step(stb, d, rdy);
      check("rnd valid", 32'(bus.o_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         check("rnd data", 32'(bus.o_data), 32'(mq[0][7:0]));
         check("rnd last", 32'(bus.o_last), 32'(mq[0][8]));
      end
      check("rnd ok",  32'(bus.o_frame_ok), 32'(m_ok));
      check("rnd err", 32'(bus.o_frame_err), 32'(m_err));
      if (m_err) check("rnd code", 32'(bus.o_err_code), 32'(m_code));
   endtask

   task automatic send(input logic [7:0] b);
      repeat ($urandom_range(0, 2)) rstep(1'b0, 8'h00);
      rstep(1'b1, b);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         early, pulses, len;
      logic [7:0] b, s, c;

      bus.i_rx_stb  = 1'b0;
      bus.i_rx_data = 8'h00;
      bus.i_ready   = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset");

      // Release: edge 1 is ignored, edge 2 is the first active one.
      rst_n = 1'b1;
      step(1'b1, 8'h7E, 1'b0);
      step(1'b1, 8'h7E, 1'b0);
      check("release no len err", 32'(bus.o_frame_err), 32'd0);
      step(1'b1, 8'h01, 1'b0);
      step(1'b1, 8'h55, 1'b0);
      check("release valid", 32'(bus.o_valid), 32'd1);
      check("release data",  32'(bus.o_data), 32'h55);
      check("release last",  32'(bus.o_last), 32'd1);
      step(1'b1, 8'hAA, 1'b0);
      check("release ok", 32'(bus.o_frame_ok), 32'd1);
      step(1'b0, 8'h00, 1'b1);
      check("release drained", 32'(bus.o_valid), 32'd0);

      // good frame
      add(1, 8'h7E, 0, 8'h00, 0, 0, 0, 2'b00);
      add(1, 8'h03, 0, 8'h00, 0, 0, 0, 2'b00);
      add(1, 8'h11, 1, 8'h11, 0, 0, 0, 2'b00);
      add(1, 8'h22, 1, 8'h22, 0, 0, 0, 2'b00);
      add(1, 8'h33, 1, 8'h33, 1, 0, 0, 2'b00);
      add(1, 8'h97, 0, 8'h00, 0, 1, 0, 2'b00);
      add(0, 8'h00, 0, 8'h00, 0, 0, 0, 2'b00);
      // bad checksum
      add(1, 8'h7E, 0, 8'h00, 0, 0, 0, 2'b00);
      add(1, 8'h02, 0, 8'h00, 0, 0, 0, 2'b00);
      add(1, 8'h01, 1, 8'h01, 0, 0, 0, 2'b00);
      add(1, 8'h02, 1, 8'h02, 1, 0, 0, 2'b00);
      add(1, 8'h00, 0, 8'h00, 0, 0, 1, 2'b00);
      add(0, 8'h00, 0, 8'h00, 0, 0, 0, 2'b00);
      // zero length, then over-long length
      add(1, 8'h7E, 0, 8'h00, 0, 0, 0, 2'b00);
      add(1, 8'h00, 0, 8'h00, 0, 0, 1, 2'b01);
      add(1, 8'h7E, 0, 8'h00, 0, 0, 0, 2'b00);
      add(1, 8'h41, 0, 8'h00, 0, 0, 1, 2'b01);
      add(0, 8'h00, 0, 8'h00, 0, 0, 0, 2'b00);
      // good frame right after the length errors
      add(1, 8'h7E, 0, 8'h00, 0, 0, 0, 2'b00);
      add(1, 8'h01, 0, 8'h00, 0, 0, 0, 2'b00);
      add(1, 8'h5A, 1, 8'h5A, 1, 0, 0, 2'b00);
      add(1, 8'hA5, 0, 8'h00, 0, 1, 0, 2'b00);
      // leading noise, and a sync value inside the payload taken as data
      add(1, 8'h00, 0, 8'h00, 0, 0, 0, 2'b00);
      add(1, 8'hFF, 0, 8'h00, 0, 0, 0, 2'b00);
      add(1, 8'h7E, 0, 8'h00, 0, 0, 0, 2'b00);
      add(1, 8'h02, 0, 8'h00, 0, 0, 0, 2'b00);
      add(1, 8'h7E, 1, 8'h7E, 0, 0, 0, 2'b00);
      add(1, 8'h10, 1, 8'h10, 1, 0, 0, 2'b00);
      add(1, 8'h70, 0, 8'h00, 0, 1, 0, 2'b00);
      // 0x87 leaves 0x69+0x87 = 0xF0, so this one is a checksum failure
      add(1, 8'h7E, 0, 8'h00, 0, 0, 0, 2'b00);
      add(1, 8'h03, 0, 8'h00, 0, 0, 0, 2'b00);
      add(1, 8'h11, 1, 8'h11, 0, 0, 0, 2'b00);
      add(1, 8'h22, 1, 8'h22, 0, 0, 0, 2'b00);
      add(1, 8'h33, 1, 8'h33, 1, 0, 0, 2'b00);
      add(1, 8'h87, 0, 8'h00, 0, 0, 1, 2'b00);
      add(0, 8'h00, 0, 8'h00, 0, 0, 0, 2'b00);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].stb, tbl[i].d, tbl[i].rdy);
         check($sformatf("vec%0d valid", i), 32'(bus.o_valid), 32'(tbl[i].v));
         if (tbl[i].v) begin
            check($sformatf("vec%0d data", i), 32'(bus.o_data), 32'(tbl[i].od));
            check($sformatf("vec%0d last", i), 32'(bus.o_last), 32'(tbl[i].ol));
         end
         check($sformatf("vec%0d ok", i),  32'(bus.o_frame_ok), 32'(tbl[i].ok));
         check($sformatf("vec%0d err", i), 32'(bus.o_frame_err), 32'(tbl[i].err));
         if (tbl[i].err) check($sformatf("vec%0d code", i), 32'(bus.o_err_code), 32'(tbl[i].code));
      end

      // timeout after one payload byte; the byte stays queued
      step(1'b1, 8'h7E, 1'b0);
      step(1'b1, 8'h05, 1'b0);
      step(1'b1, 8'hAA, 1'b0);
      check("tmo head valid", 32'(bus.o_valid), 32'd1);
      check("tmo head data",  32'(bus.o_data), 32'hAA);
      early = 0;
      for (int i = 1; i < TMO; i++) begin
         step(1'b0, 8'h00, 1'b0);
         if (bus.o_frame_err || bus.o_frame_ok) early++;
      end
      check("tmo early pulse", 32'(early), 32'd0);
      step(1'b0, 8'h00, 1'b0);
      check("tmo err",  32'(bus.o_frame_err), 32'd1);
      check("tmo code", 32'(bus.o_err_code), 32'd2);
      check("tmo ok",   32'(bus.o_frame_ok), 32'd0);
      check("tmo kept valid", 32'(bus.o_valid), 32'd1);
      check("tmo kept data",  32'(bus.o_data), 32'hAA);
      step(1'b0, 8'h00, 1'b0);
      check("tmo err width", 32'(bus.o_frame_err), 32'd0);
      step(1'b0, 8'h00, 1'b1);
      check("tmo drained", 32'(bus.o_valid), 32'd0);

      // overflow: six bytes into a four-deep FIFO with no pops
      step(1'b1, 8'h7E, 1'b0);
      step(1'b1, 8'h06, 1'b0);
      for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 1'b0);
      step(1'b1, 8'hE5, 1'b0);
      check("ovf err",  32'(bus.o_frame_err), 32'd1);
      check("ovf code", 32'(bus.o_err_code), 32'd3);
      check("ovf ok",   32'(bus.o_frame_ok), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ovf held%0d valid", i), 32'(bus.o_valid), 32'd1);
         check($sformatf("ovf held%0d data", i),  32'(bus.o_data), 32'(i + 1));
         check($sformatf("ovf held%0d last", i),  32'(bus.o_last), 32'd0);
         step(1'b0, 8'h00, 1'b1);
      end
      check("ovf drained", 32'(bus.o_valid), 32'd0);

      // reset in the middle of a payload
      step(1'b1, 8'h7E, 1'b0);
      step(1'b1, 8'h04, 1'b0);
      step(1'b1, 8'h01, 1'b0);
      step(1'b1, 8'h02, 1'b0);
      check("midrst pre valid", 32'(bus.o_valid), 32'd1);
      check("midrst pre data",  32'(bus.o_data), 32'h01);
      do_reset();
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 8'h00, 1'b1);
         if (bus.o_frame_ok || bus.o_frame_err || bus.o_valid) pulses++;
      end
      check("midrst quiet", 32'(pulses), 32'd0);

      // randomized frames against the reference model
      mq.delete();
      m_in_frame = 0;
      m_idle     = 0;
      for (int f = 0; f < 200; f++) begin
         case ($urandom_range(0, 3))
            0:       rdy_pct = 100;
            1:       rdy_pct = 80;
            2:       rdy_pct = 50;
            default: rdy_pct = 20;
         endcase
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom());
            if (b == SYNC) b = 8'h00;
            send(b);
         end
         send(SYNC);
         case ($urandom_range(0, 9))
            0:       len = 0;
            1:       len = $urandom_range(65, 255);
            2:       len = $urandom_range(1, 64);
            default: len = $urandom_range(1, 12);
         endcase
         send(8'(len));
         if (len == 0 || len > 64) continue;
         s = 8'(len);
         for (int k = 0; k < len; k++) begin
            b = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom());
            s = s + b;
            send(b);
         end
         c = 8'h00 - s;
         if ($urandom_range(0, 4) == 0) c = c ^ 8'($urandom_range(1, 255));
         send(c);
      end
      rdy_pct = 100;
      repeat (10) rstep(1'b0, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
